sd_sector_writer: RTL and testbench
===================================

Name: sd_sector_writer

Overview:
- Upstream feeder for the SD controller write port in the data-acquisition path.
- Packs a continuous 16-bit sample stream into 256-word (512-byte) sectors using a two-bank ping-pong buffer.
- Issues one write command per full sector at consecutive sector addresses and serves the controller's per-word data requests.
- Flags samples lost when both banks are full.

Parameters:
- START_SEC, 32'd20000, sector address of the first sector written after reset.
- SEC_WORDS, 256, 16-bit words per sector; fixed by the SD controller, not to be overridden.
- MAX_SECS, 32'd1000000, number of sectors after which recording stops (disk region size).

Ports:
- clk  in  1  system clock; same domain as the SD controller user side.
- rst_n  in  1  reset; asynchronous, active-low.
- sd_init_done  in  1  SD initialisation complete; level signal.
- rec_en  in  1  recording enable; samples are accepted only while high.
- smp_valid  in  1  single-cycle strobe marking smp_data as valid.
- smp_data  in  16  sample word.
- wr_busy  in  1  SD controller write busy.
- wr_req  in  1  SD controller request for the next data word; single-cycle pulse.
- wr_start_en  out  1  one-cycle pulse that starts a sector write.
- wr_sec_addr  out  32  sector address; stable while wr_busy is high.
- wr_data  out  16  write data word.
- sec_cnt  out  32  number of sectors completed.
- ovf_flag  out  1  sticky flag: at least one sample was dropped.
- done_flag  out  1  high once MAX_SECS sectors have been written.

Behaviour:
- Reset values: all outputs 0, except wr_sec_addr = START_SEC. Both banks empty; fill bank = 0; drain bank = 0; FSM in S_IDLE.
- Fill side:
  - When smp_valid && rec_en && !done_flag && the fill bank is not full, write smp_data to the fill bank at wr_ptr and increment wr_ptr.
  - At wr_ptr = 255, the write marks the bank full, switches the fill bank, and resets wr_ptr to 0.
  - If the other bank is still full (not yet drained), the switch is deferred.
  - While deferred, incoming samples are dropped and ovf_flag is set; it clears only on reset.
  - A partial bank is retained when rec_en drops and resumes filling when rec_en returns.
- FSM states:
  - S_IDLE: wait for sd_init_done as a registered, synchronised level; move to S_WAIT.
  - S_WAIT: when the drain bank is full and !done_flag, go to S_START.
  - S_START: drive wr_start_en high for exactly one cycle; go to S_ACK.
  - S_ACK: wait for wr_busy = 1; go to S_BUSY.
  - S_BUSY: on the falling edge of wr_busy, detected with a two-stage register:
    - mark the drain bank empty and toggle the drain bank;
    - increment sec_cnt and wr_sec_addr;
    - set done_flag when sec_cnt reaches MAX_SECS;
    - go to S_WAIT.
- Read side:
  - rd_ptr resets to 0 in S_START and increments on each wr_req.
  - The buffer RAM has a registered read with 1-cycle latency.
  - Word k (k = 0..255) appears on wr_data the cycle after the (k+1)th wr_req and holds until the next wr_req.
  - wr_req pulses beyond 256 in one sector are ignored; rd_ptr saturates and wr_data holds word 255.
- Simultaneous events:
  - A bank-full on the fill side and a drain completion in the same cycle are both honoured. The freed bank becomes the fill bank immediately, and no sample is dropped.
- Address arithmetic: 32-bit unsigned; wrap is unreachable because of MAX_SECS.
- Reset mid-sector: the sector being written is abandoned; the controller's own reset recovers the card.

Optional Feature:
- Macro: SD_SEC_TAG_EN.
- Defined: word 0 of every sector is forced to sec_cnt[15:0], latched in S_START. Samples fill words 1..255 only, so the fill side counts 255 samples per bank.
- Undefined: all 256 words are samples; no tag logic is generated.

Decomposition:
- Package sd_wr_pkg:
  - FSM state encoding (S_IDLE, S_WAIT, S_START, S_ACK, S_BUSY);
  - SEC_WORDS constant;
  - sector-address width of 32.
- One sub-module, sd_pingpong_ram: a simple dual-port 512x16 RAM with one write port and a registered read port. Address = {bank, ptr[7:0]}.

Test Plan:
- Reset, sd_init_done = 1, rec_en = 1, 256 samples 0..255 at one per 4 clk, BFM controller issuing 256 wr_req -> exactly one wr_start_en pulse, wr_sec_addr = 20000, BFM captures 0..255, sec_cnt = 1.
- 1024 consecutive samples with BFM writes taking 2000 cycles each -> 4 sectors at addresses 20000..20003, data continuous, ovf_flag = 0.
- Samples every cycle with BFM wr_busy held 5000 cycles -> ovf_flag = 1 after sample 512; the first sector contains 0..255 intact.
- rec_en dropped after 100 samples for 1000 cycles, then 156 more samples -> a single sector holding all 256 samples in order.
- MAX_SECS = 2, feed 768 samples -> 2 write pulses only, done_flag = 1, third bank never drained.
- With SD_SEC_TAG_EN, two sectors -> word 0 = 0x0000 then 0x0001; words 1..255 are sequential samples.

Source files
------------

// File: rtl/sd_wr_pkg.sv
// -----------------------------------------------------------------------------
// sd_wr_pkg
// Shared definitions for the SD sector writer:
//   - wr_state_t : write-side FSM state encoding
//   - SEC_WORDS  : 16-bit words per SD sector (fixed by the SD controller)
//   - SEC_ADDR_W : sector address width
//   - PTR_W      : word pointer width inside one sector
//   - BUF_AW     : ping-pong buffer address width ({bank, ptr})
// -----------------------------------------------------------------------------
package sd_wr_pkg;

    localparam int SEC_WORDS  = 256;
    localparam int SEC_ADDR_W = 32;
    localparam int PTR_W      = 8;
    localparam int BUF_AW     = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_ACK,
        S_BUSY
    } wr_state_t;

endpackage

// File: rtl/sd_pingpong_ram.sv
// -----------------------------------------------------------------------------
// sd_pingpong_ram
// Simple dual-port 512x16 buffer holding two sector banks.
// Address = {bank, ptr[7:0]}. One write port, one registered read port with
// 1-cycle latency; the read register holds its value while re is low.
//
// Ports:
//   clk, rst_n  clock / async active-low reset (read register only)
//   we          write enable
//   waddr       write address {bank, ptr}
//   wdata       write data
//   re          read enable
//   raddr       read address {bank, ptr}
//   rdata       registered read data
// -----------------------------------------------------------------------------
module sd_pingpong_ram
    import sd_wr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [BUF_AW-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic              re,
    input  logic [BUF_AW-1:0] raddr,
    output logic [15:0]       rdata
);

    localparam int DEPTH = 2 * SEC_WORDS;

    logic [15:0] mem [0:DEPTH-1];

    // NOTE: the storage array has no reset; clearing it would prevent block-RAM
    // inference, and every word is written before it is ever read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sd_sector_writer.sv
// -----------------------------------------------------------------------------
// sd_sector_writer
// Packs a 16-bit sample stream into 256-word sectors using a two-bank
// ping-pong buffer and feeds them to the SD controller write port, one write
// command per full sector at consecutive sector addresses.
//
// Build option: define SD_SEC_TAG_EN to force word 0 of every sector to the
// low 16 bits of the sector count (samples then fill words 1..255).
//
// Ports:
//   clk, rst_n    system clock / async active-low reset
//   sd_init_done  SD card initialised (level, synchronised internally)
//   rec_en        recording enable
//   smp_valid     sample strobe, smp_data valid
//   smp_data      sample word
//   wr_busy       SD controller write busy
//   wr_req        SD controller request for next data word (pulse)
//   wr_start_en   one-cycle sector write start pulse
//   wr_sec_addr   sector address of the current / next write
//   wr_data       write data word
//   sec_cnt       sectors completed
//   ovf_flag      sticky: at least one sample dropped
//   done_flag     MAX_SECS sectors written, recording stopped
// -----------------------------------------------------------------------------
module sd_sector_writer #(
    parameter logic [31:0] START_SEC = 32'd20000,
    parameter int          SEC_WORDS = sd_wr_pkg::SEC_WORDS,
    parameter logic [31:0] MAX_SECS  = 32'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sd_init_done,
    input  logic        rec_en,
    input  logic        smp_valid,
    input  logic [15:0] smp_data,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    output logic [15:0] wr_data,
    output logic [31:0] sec_cnt,
    output logic        ovf_flag,
    output logic        done_flag
);

    import sd_wr_pkg::*;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SEC_WORDS - 1);
    localparam logic [PTR_W:0]   RD_END   = (PTR_W + 1)'(SEC_WORDS);
`ifdef SD_SEC_TAG_EN
    // Word 0 carries the tag, so samples start at word 1.
    localparam logic [PTR_W-1:0] FIRST_PTR = PTR_W'(1);
`else
    localparam logic [PTR_W-1:0] FIRST_PTR = '0;
`endif

    wr_state_t        state, state_next;
    logic             init_s1, init_s2;
    logic             busy_d1, busy_d2;
    logic [1:0]       bank_full, full_next;
    logic             fill_bank, drain_bank;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   rd_cnt;
    logic [15:0]      ram_q;

    logic smp_take, fill_we, fill_last, fill_switch;
    logic busy_fall, drain_done, rd_take;

    // ------------------------------------------------------------------ fill
    assign smp_take  = smp_valid && rec_en && !done_flag;
    assign fill_we   = smp_take && !bank_full[fill_bank];
    assign fill_last = fill_we && (wr_ptr == LAST_PTR);

    assign busy_fall  = busy_d2 && !busy_d1;
    assign drain_done = (state == S_BUSY) && busy_fall;

    // Bank occupancy after this cycle. A drain completion and a bank filling
    // up in the same cycle are both applied, so the freed bank can take over
    // as fill bank on the very next sample.
    always_comb begin
        full_next = bank_full;
        if (drain_done) begin
            full_next[drain_bank] = 1'b0;
        end
        if (fill_last) begin
            full_next[fill_bank] = 1'b1;
        end
    end

    // Move on once the current fill bank is full and the other one is free;
    // this also covers the deferred switch while the other bank drains.
    assign fill_switch = full_next[fill_bank] && !full_next[!fill_bank];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= '0;
            fill_bank <= 1'b0;
            wr_ptr    <= FIRST_PTR;
            ovf_flag  <= 1'b0;
        end else begin
            bank_full <= full_next;
            if (fill_we) begin
                wr_ptr <= fill_last ? FIRST_PTR : wr_ptr + PTR_W'(1);
            end
            if (fill_switch) begin
                fill_bank <= !fill_bank;
            end
            if (smp_take && bank_full[fill_bank]) begin
                ovf_flag <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            init_s1 <= 1'b0;
            init_s2 <= 1'b0;
            busy_d1 <= 1'b0;
            busy_d2 <= 1'b0;
        end else begin
            state   <= state_next;
            init_s1 <= sd_init_done;
            init_s2 <= init_s1;
            busy_d1 <= wr_busy;
            busy_d2 <= busy_d1;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        wr_start_en = 1'b0;
        case (state)
            S_IDLE:  if (init_s2) state_next = S_WAIT;
            S_WAIT:  if (bank_full[drain_bank] && !done_flag) state_next = S_START;
            S_START: begin
                wr_start_en = 1'b1;
                state_next  = S_ACK;
            end
            S_ACK:   if (wr_busy) state_next = S_BUSY;
            S_BUSY:  if (busy_fall) state_next = S_WAIT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_bank  <= 1'b0;
            sec_cnt     <= '0;
            wr_sec_addr <= START_SEC;
            done_flag   <= 1'b0;
        end else if (drain_done) begin
            drain_bank  <= !drain_bank;
            sec_cnt     <= sec_cnt + 32'd1;
            wr_sec_addr <= wr_sec_addr + 32'd1;
            if (sec_cnt + 32'd1 == MAX_SECS) begin
                done_flag <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- read side
    // rd_cnt runs 0..SEC_WORDS; requests past the last word are ignored so the
    // read register keeps presenting word 255.
    assign rd_take = wr_req && (rd_cnt != RD_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
        end else if (state == S_START) begin
            rd_cnt <= '0;
        end else if (rd_take) begin
            rd_cnt <= rd_cnt + (PTR_W + 1)'(1);
        end
    end

    sd_pingpong_ram u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (fill_we),
        .waddr ({fill_bank, wr_ptr}),
        .wdata (smp_data),
        .re    (rd_take),
        .raddr ({drain_bank, rd_cnt[PTR_W-1:0]}),
        .rdata (ram_q)
    );

`ifdef SD_SEC_TAG_EN
    logic [15:0] tag_q;
    logic        tag_sel;

    // tag_sel tracks which word the read register currently holds, so the tag
    // is muxed in with the same 1-cycle latency as RAM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            tag_sel <= 1'b0;
        end else begin
            if (state == S_START) begin
                tag_q <= sec_cnt[15:0];
            end
            if (rd_take) begin
                tag_sel <= (rd_cnt == '0);
            end
        end
    end

    assign wr_data = tag_sel ? tag_q : ram_q;
`else
    assign wr_data = ram_q;
`endif

endmodule

// File: tb/tb_sd_sector_writer.sv
// -----------------------------------------------------------------------------
// tb_sd_sector_writer
// Self-checking bench for sd_sector_writer: a controller BFM captures every
// sector, and a sample-level reference model (queue of accepted samples with
// a two-sector capacity limit) predicts sector contents and the overflow flag.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sd_sector_writer;

    localparam logic [31:0] START_SEC = 32'd20000;
    localparam logic [31:0] TB_MAX    = 32'd6;
    localparam int          WORDS     = 256;
`ifdef SD_SEC_TAG_EN
    localparam int SMP_PER_SEC = WORDS - 1;
`else
    localparam int SMP_PER_SEC = WORDS;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sd_init_done = 1'b0;
    logic        rec_en = 1'b0;
    logic        smp_valid = 1'b0;
    logic [15:0] smp_data = '0;
    logic        wr_busy;
    logic        wr_req;
    logic        wr_start_en;
    logic [31:0] wr_sec_addr;
    logic [15:0] wr_data;
    logic [31:0] sec_cnt;
    logic        ovf_flag;
    logic        done_flag;

    sd_sector_writer #(
        .START_SEC (START_SEC),
        .MAX_SECS  (TB_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sd_init_done (sd_init_done),
        .rec_en       (rec_en),
        .smp_valid    (smp_valid),
        .smp_data     (smp_data),
        .wr_busy      (wr_busy),
        .wr_req       (wr_req),
        .wr_start_en  (wr_start_en),
        .wr_sec_addr  (wr_sec_addr),
        .wr_data      (wr_data),
        .sec_cnt      (sec_cnt),
        .ovf_flag     (ovf_flag),
        .done_flag    (done_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ------------------------------------------------------------ BFM state
    int          bfm_busy_cycles = 600;
    int          bfm_extra       = 0;
    logic [15:0] got_q[$];
    logic [15:0] extra_q[$];
    logic [31:0] addr_q[$];
    int          bfm_done  = 0;
    int          pulse_err = 0;
    int          addr_err  = 0;
    int          start_seen = 0;

    always @(negedge clk) begin
        if (wr_start_en === 1'b1) start_seen <= start_seen + 1;
    end

    // SD controller model: on a start pulse, raise busy, issue SEC_WORDS
    // (+ extra) data requests two cycles apart, capture the word one cycle
    // after each request, hold busy for bfm_busy_cycles, then drop it.
    initial begin : bfm
        int cyc;
        wr_busy = 1'b0;
        wr_req  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && wr_start_en === 1'b1) begin
                addr_q.push_back(wr_sec_addr);
                @(negedge clk);
                if (wr_start_en !== 1'b0) pulse_err++;
                wr_busy = 1'b1;
                cyc = 1;
                for (int k = 0; k < WORDS + bfm_extra; k++) begin
                    @(negedge clk);
                    wr_req = 1'b1;
                    @(negedge clk);
                    wr_req = 1'b0;
                    cyc += 2;
                    if (k < WORDS) got_q.push_back(wr_data);
                    else           extra_q.push_back(wr_data);
                    if (wr_sec_addr !== addr_q[$]) addr_err++;
                end
                while (cyc < bfm_busy_cycles) begin
                    @(negedge clk);
                    cyc++;
                end
                if (wr_sec_addr !== addr_q[$]) addr_err++;
                wr_busy = 1'b0;
                // The writer recognises the busy fall two register stages later.
                repeat (2) @(negedge clk);
                bfm_done++;
            end
        end
    end

    // -------------------------------------------------------- reference model
    logic [15:0] exp_q[$];
    bit          model_ovf;
    int          got_base, extra_base, addr_base, done_base, start_base;

    function automatic int drained();
        return bfm_done - done_base;
    endfunction

    // A sample is kept when recording, not finished, and fewer than two
    // sectors' worth of samples are waiting to be written.
    task automatic model_offer(input logic [15:0] v);
        if (rec_en && drained() < int'(TB_MAX)) begin
            if (exp_q.size() - SMP_PER_SEC * drained() < 2 * SMP_PER_SEC)
                exp_q.push_back(v);
            else
                model_ovf = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        smp_valid    = 1'b0;
        rec_en       = 1'b0;
        sd_init_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n      = 1'b1;
        exp_q.delete();
        model_ovf  = 1'b0;
        got_base   = got_q.size();
        extra_base = extra_q.size();
        addr_base  = addr_q.size();
        done_base  = bfm_done;
        start_base = start_seen;
        @(negedge clk);
    endtask

    task automatic feed(input int n, input int gmin, input int gmax,
                        input bit counting, input int val0);
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            v = counting ? 16'(val0 + i) : 16'($urandom);
            smp_data  = v;
            smp_valid = 1'b1;
            model_offer(v);
            @(negedge clk);
            smp_valid = 1'b0;
            repeat ($urandom_range(gmax, gmin) - 1) @(negedge clk);
        end
    endtask

    task automatic wait_sectors(input string tag, input int n, input int budget);
        int t = 0;
        while (drained() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_sectors_done"}, drained(), n);
    endtask

    task automatic check_sectors(input string tag, input int nsec);
        logic [15:0] exp;
        int          idx;
        for (int s = 0; s < nsec; s++) begin
            check($sformatf("%s_addr%0d", tag, s), addr_q[addr_base + s], START_SEC + s);
            for (int w = 0; w < WORDS; w++) begin
`ifdef SD_SEC_TAG_EN
                if (w == 0) exp = 16'(s);
                else        exp = exp_q[s * SMP_PER_SEC + w - 1];
`else
                exp = exp_q[s * SMP_PER_SEC + w];
`endif
                idx = got_base + s * WORDS + w;
                check($sformatf("%s_s%0d_w%0d", tag, s, w),
                      (idx < got_q.size()) ? 32'(got_q[idx]) : 32'hdead_beef, 32'(exp));
            end
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin : main
        // Reset state
        do_reset();
        check("rst_start_en", wr_start_en, 0);
        check("rst_sec_addr", wr_sec_addr, START_SEC);
        check("rst_wr_data",  wr_data, 0);
        check("rst_sec_cnt",  sec_cnt, 0);
        check("rst_ovf",      ovf_flag, 0);
        check("rst_done",     done_flag, 0);

        // T1: one sector of 0..N, plus requests beyond the last word
        sd_init_done    = 1'b1;
        rec_en          = 1'b1;
        bfm_busy_cycles = 700;
        bfm_extra       = 2;
        feed(SMP_PER_SEC, 4, 4, 1'b1, 0);
        wait_sectors("t1", 1, 5000);
        repeat (100) @(negedge clk);
        check("t1_starts", start_seen - start_base, 1);
        check_sectors("t1", 1);
        check("t1_sat0", extra_q[extra_base],     exp_q[SMP_PER_SEC - 1]);
        check("t1_sat1", extra_q[extra_base + 1], exp_q[SMP_PER_SEC - 1]);
        check("t1_sec_cnt", sec_cnt, 1);
        check("t1_next_addr", wr_sec_addr, START_SEC + 1);
        check("t1_ovf", ovf_flag, model_ovf);
        check("t1_done", done_flag, 0);

        // T2: four sectors with slow writes, sample rate below drain rate
        do_reset();
        sd_init_done    = 1'b1;
        rec_en          = 1'b1;
        bfm_busy_cycles = 2000;
        bfm_extra       = 0;
        feed(4 * SMP_PER_SEC, 9, 12, 1'b0, 0);
        wait_sectors("t2", 4, 20000);
        repeat (100) @(negedge clk);
        check("t2_starts", start_seen - start_base, 4);
        check_sectors("t2", 4);
        check("t2_sec_cnt", sec_cnt, 4);
        check("t2_ovf", ovf_flag, model_ovf);

        // T3: samples every cycle while the first write stalls -> overflow
        do_reset();
        sd_init_done    = 1'b1;
        rec_en          = 1'b1;
        bfm_busy_cycles = 5000;
        feed(2 * SMP_PER_SEC, 1, 1, 1'b0, 0);
        check("t3_ovf_before", ovf_flag, model_ovf);
        feed(88, 1, 1, 1'b0, 0);
        check("t3_ovf_after", ovf_flag, model_ovf);
        wait_sectors("t3", 2, 20000);
        repeat (100) @(negedge clk);
        check("t3_starts", start_seen - start_base, 2);
        check_sectors("t3", 2);
        check("t3_ovf_sticky", ovf_flag, 1);

        // T4: recording paused mid-sector, strobes ignored while paused
        do_reset();
        sd_init_done    = 1'b1;
        rec_en          = 1'b1;
        bfm_busy_cycles = 700;
        feed(100, 2, 5, 1'b0, 0);
        rec_en = 1'b0;
        feed(40, 20, 30, 1'b0, 0);
        rec_en = 1'b1;
        feed(SMP_PER_SEC - 100, 2, 5, 1'b0, 0);
        wait_sectors("t4", 1, 5000);
        repeat (300) @(negedge clk);
        check("t4_starts", start_seen - start_base, 1);
        check_sectors("t4", 1);
        check("t4_sec_cnt", sec_cnt, 1);
        check("t4_ovf", ovf_flag, model_ovf);

        // T5: recording stops after MAX_SECS sectors; last bank never drained
        do_reset();
        sd_init_done    = 1'b1;
        rec_en          = 1'b1;
        bfm_busy_cycles = 600;
        feed(7 * SMP_PER_SEC, 3, 4, 1'b0, 0);
        wait_sectors("t5", int'(TB_MAX), 30000);
        repeat (2000) @(negedge clk);
        check("t5_starts", start_seen - start_base, TB_MAX);
        check_sectors("t5", int'(TB_MAX));
        check("t5_done", done_flag, 1);
        check("t5_sec_cnt", sec_cnt, TB_MAX);
        check("t5_next_addr", wr_sec_addr, START_SEC + TB_MAX);
        check("t5_ovf", ovf_flag, 0);

        // Protocol checks accumulated by the BFM over the whole run
        check("start_pulse_width_errors", pulse_err, 0);
        check("addr_stability_errors", addr_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
